// File: rtl/filter_load_sequencer.sv
// filter_load_sequencer: loads a layer's bias and 5x5 filters into the filter buffer; `FLS_TIMEOUT_EN adds a per-state watchdog
module filter_load_sequencer #(
   parameter int MAX_FILTERS = 1920,
   parameter int IDX_W       = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] num_filters,
   input  logic [IDX_W-1:0] base_addr,
   output logic             mem_req,
   output logic [IDX_W-1:0] mem_addr,
   input  logic             mem_valid,
   output logic             buf_read,
   output logic             buf_bias_or_filter,
   output logic [IDX_W-1:0] buf_index,
   input  logic             buf_finish,
   output logic             busy,
   output logic             done,
   output logic             error
);
   typedef enum logic [2:0] {IDLE, B_REQ, B_WR, B_REL, F_REQ, F_WR, F_REL, DONE} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] num_q, base_q, i_q;
   logic rej_q, accept, illegal, last, tmo;
   assign accept    = state == IDLE && start;
   assign illegal   = num_filters == '0 || num_filters > IDX_W'(MAX_FILTERS);
   assign last      = i_q == num_q - IDX_W'(1);
   assign buf_index = i_q;
   assign busy      = state != IDLE;
   assign done      = state == DONE || rej_q;
`ifdef FLS_TIMEOUT_EN
   logic [IDX_W-1:0] cyc_q;
   // cycles spent in the current transfer state, restarted on every state change
   always_ff @(posedge clk) begin
      if (!reset || state_n != state || state == IDLE || state == DONE) cyc_q <= '0;
      else cyc_q <= cyc_q + IDX_W'(1);
   end
   assign tmo = state != IDLE && state != DONE && cyc_q == IDX_W'(TIMEOUT_CYC - 1);
`else
   assign tmo = TIMEOUT_CYC < 0;
`endif
   // state, latched load parameters, filter counter and sticky error
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         num_q  <= '0;
         base_q <= '0;
         i_q    <= '0;
         rej_q  <= 1'b0;
         error  <= 1'b0;
      end else begin
         state <= state_n;
         rej_q <= accept && illegal;
         error <= accept ? illegal : error | tmo;
         if (accept) begin
            num_q  <= num_filters;
            base_q <= base_addr;
            i_q    <= '0;
         end else if (state == F_REL && !buf_finish && !last) i_q <= i_q + IDX_W'(1);
      end
   end
   // next state plus state-decoded handshake outputs; a watchdog expiry forces DONE
   always_comb begin
      state_n            = state;
      mem_req            = 1'b0;
      buf_read           = 1'b0;
      buf_bias_or_filter = 1'b0;
      mem_addr           = '0;
      case (state)
         IDLE:    state_n = start && !illegal ? B_REQ : IDLE;
         B_REQ: begin
            mem_req  = 1'b1;
            mem_addr = base_q;
            state_n  = mem_valid ? B_WR : B_REQ;
         end
         B_WR: begin
            buf_read = 1'b1;
            state_n  = buf_finish ? B_REL : B_WR;
         end
         B_REL:   state_n = buf_finish ? B_REL : F_REQ;
         F_REQ: begin
            mem_req            = 1'b1;
            buf_bias_or_filter = 1'b1;
            mem_addr           = base_q + i_q + IDX_W'(1);
            state_n            = mem_valid ? F_WR : F_REQ;
         end
         F_WR: begin
            buf_read           = 1'b1;
            buf_bias_or_filter = 1'b1;
            state_n            = buf_finish ? F_REL : F_WR;
         end
         F_REL: begin
            buf_bias_or_filter = 1'b1;
            state_n            = buf_finish ? F_REL : last ? DONE : F_REQ;
         end
         DONE:    state_n = IDLE;
      endcase
      if (tmo) state_n = DONE;
   end
endmodule
